mem_port_arbiter: RTL and testbench

Shares the single-ported instruction/data memory between the CPU's instruction-fetch port and its load/store port. Sits between `cpu` and the memory, replacing the direct fetch-to-ROM connection. It owns the memory's chip-enable and address lines, sequences each access over a fixed latency and returns a one-cycle ready pulse to the winning requester. Arbitration gives loads/stores priority, with a bounded-streak rule so fetch is never starved.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store
// port. Load/store wins ties, but only for a bounded streak while fetch waits.
// Each access: IDLE (arbitrate, latch) -> ACCESS x MEM_LAT -> RESP (ready).
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                if_ready_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_ready_o,
    output logic                ram_ce_o,
    output logic                ram_we_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    output logic [DATA_W/8-1:0] ram_sel_o,
    input  logic [DATA_W-1:0]   ram_rdata_i,
    output logic                busy_o
);
    localparam int SEL_W = DATA_W / 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } req_t;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state, state_nxt;
    logic       owner_mem;   // 1 = load/store port owns the current access
    logic       we_q;
    logic [3:0] streak;      // consecutive mem grants while fetch was waiting
    logic [3:0] cnt;         // remaining ACCESS cycles
    logic       grant_if, grant_mem;
    req_t       if_bundle, mem_bundle, win_req;

    // Arbitration: mem wins ties until the streak limit lets fetch through.
    always_comb begin
        if_bundle.we     = 1'b0;
        if_bundle.addr   = if_addr_i;
        if_bundle.wdata  = '0;
        if_bundle.sel    = '1;
        mem_bundle.we    = mem_we_i;
        mem_bundle.addr  = mem_addr_i;
        mem_bundle.wdata = mem_wdata_i;
        mem_bundle.sel   = mem_sel_i;
        grant_mem = mem_req_i && !(if_req_i && (streak == 4'(MAX_STREAK)));
        grant_if  = if_req_i && !grant_mem;
        win_req   = grant_mem ? mem_bundle : if_bundle;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_nxt   = state;
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        if_ready_o  = 1'b0;
        mem_ready_o = 1'b0;
        busy_o      = 1'b0;
        case (state)
            IDLE: begin
                if (if_req_i || mem_req_i) state_nxt = ACCESS;
            end
            ACCESS: begin
                busy_o   = 1'b1;
                ram_ce_o = 1'b1;
                ram_we_o = we_q;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP: begin
                busy_o      = 1'b1;
                if_ready_o  = !owner_mem;
                mem_ready_o = owner_mem;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latching, latency count, streak tracking and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_mem   <= 1'b0;
            we_q        <= 1'b0;
            streak      <= '0;
            cnt         <= '0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            ram_sel_o   <= '0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if || grant_mem) begin
                        owner_mem   <= grant_mem;
                        we_q        <= win_req.we;
                        ram_addr_o  <= win_req.addr;
                        ram_wdata_o <= win_req.wdata;
                        ram_sel_o   <= win_req.sel;
                        cnt         <= 4'(MEM_LAT);
                        if (grant_if || !if_req_i)
                            streak <= '0;
                        else if (streak != 4'(MAX_STREAK))
                            streak <= streak + 4'd1;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    // Stores leave the load-data register untouched.
                    if (cnt == 4'd1 && !we_q) begin
                        if (owner_mem) mem_rdata_o <= ram_rdata_i;
                        else           if_data_o   <= ram_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench: each scenario pushes expected ready events (port,
// data, cycle); negedge monitors pop and compare them as readies appear.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        bit          is_mem;
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t sbq[$];
    sb_t sbq1[$];

    // Main DUT (MEM_LAT=2, MAX_STREAK=4)
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] if_data, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ready, mem_ready, ram_ce, ram_we, busy;
    logic [3:0]  ram_sel;

    // Second DUT (MEM_LAT=1), fetch port only exercised
    logic        if_req1, mem_req1, mem_we1;
    logic [31:0] if_addr1, mem_addr1, mem_wdata1;
    logic [3:0]  mem_sel1;
    logic [31:0] if_data1, mem_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
    logic        if_ready1, mem_ready1, ram_ce1, ram_we1, busy1;
    logic [3:0]  ram_sel1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents model: fixed words at a few addresses, hash elsewhere.
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a == 32'h10) return 32'h00A00093;
        if (a == 32'h80) return 32'h0000_1234;
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    assign ram_rdata  = rd(ram_addr);
    assign ram_rdata1 = rd(ram_addr1);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel), .mem_rdata_o(mem_rdata),
        .mem_ready_o(mem_ready), .ram_ce_o(ram_ce), .ram_we_o(ram_we),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_sel_o(ram_sel),
        .ram_rdata_i(ram_rdata), .busy_o(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STREAK(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req1), .if_addr_i(if_addr1), .if_data_o(if_data1), .if_ready_o(if_ready1),
        .mem_req_i(mem_req1), .mem_we_i(mem_we1), .mem_addr_i(mem_addr1),
        .mem_wdata_i(mem_wdata1), .mem_sel_i(mem_sel1), .mem_rdata_o(mem_rdata1),
        .mem_ready_o(mem_ready1), .ram_ce_o(ram_ce1), .ram_we_o(ram_we1),
        .ram_addr_o(ram_addr1), .ram_wdata_o(ram_wdata1), .ram_sel_o(ram_sel1),
        .ram_rdata_i(ram_rdata1), .busy_o(busy1)
    );

    // Scoreboard consumer for the main DUT.
    sb_t         e0;
    logic [31:0] gd0;
    always @(negedge clk) begin
        if (if_ready && mem_ready) begin
            n_checks++; n_fail++;
            $display("FAIL dual_ready: got both readies at cycle %0d, required at most one", cyc);
        end else if (if_ready || mem_ready) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: got if=%0b mem=%0b at cycle %0d, required none", if_ready, mem_ready, cyc);
            end else begin
                e0  = sbq.pop_front();
                gd0 = mem_ready ? mem_rdata : if_data;
                if (mem_ready !== e0.is_mem || gd0 !== e0.data || cyc !== e0.cyc) begin
                    n_fail++;
                    $display("FAIL sb_main: got mem=%0b data=%h cycle=%0d, required mem=%0b data=%h cycle=%0d",
                             mem_ready, gd0, cyc, e0.is_mem, e0.data, e0.cyc);
                end
            end
        end
    end

    // Scoreboard consumer for the MEM_LAT=1 DUT.
    sb_t         e1;
    logic [31:0] gd1;
    always @(negedge clk) begin
        if (if_ready1 || mem_ready1) begin
            n_checks++;
            if (sbq1.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready_lat1: got if=%0b mem=%0b at cycle %0d, required none", if_ready1, mem_ready1, cyc);
            end else begin
                e1  = sbq1.pop_front();
                gd1 = mem_ready1 ? mem_rdata1 : if_data1;
                if (mem_ready1 !== e1.is_mem || gd1 !== e1.data || cyc !== e1.cyc) begin
                    n_fail++;
                    $display("FAIL sb_lat1: got mem=%0b data=%h cycle=%0d, required mem=%0b data=%h cycle=%0d",
                             mem_ready1, gd1, cyc, e1.is_mem, e1.data, e1.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        n_checks++;
        if ({if_data, mem_rdata, ram_addr, ram_wdata, ram_sel, ram_ce, ram_we, if_ready, mem_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h wdata=%h sel=%h ce=%0b we=%0b ifd=%h memd=%h, required all 0",
                     ram_addr, ram_wdata, ram_sel, ram_ce, ram_we, if_data, mem_rdata);
        end
        n_checks++;
        if (busy !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %0b/%0b, required 0/0", busy, busy1);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_if_read();
        int c0 = cyc;
        if_req = 1'b1; if_addr = 32'h10;
        sbq.push_back('{1'b0, 32'h00A00093, c0 + 3});
        for (int k = 1; k <= 2; k++) begin
            step();
            n_checks++;
            if ({ram_ce, ram_we, ram_addr, busy} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin
                n_fail++;
                $display("FAIL if_access_c%0d: got ce=%0b we=%0b addr=%h busy=%0b, required ce=1 we=0 addr=10 busy=1",
                         k, ram_ce, ram_we, ram_addr, busy);
            end
        end
        step();
        n_checks++;
        if (ram_ce !== 1'b0 || if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL if_resp: got ce=%0b ready=%0b, required ce=0 ready=1", ram_ce, if_ready);
        end
        if_req = 1'b0;
        step();
        n_checks++;
        if ({busy, if_ready, if_data, ram_addr} !== {1'b0, 1'b0, 32'h00A00093, 32'h10}) begin
            n_fail++;
            $display("FAIL if_hold: got busy=%0b ready=%0b data=%h addr=%h, required 0 0 00a00093 10",
                     busy, if_ready, if_data, ram_addr);
        end
    endtask

    task automatic test_simultaneous();
        int c0 = cyc;
        if_req = 1'b1; if_addr = 32'h24;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_sel = 4'hF;
        sbq.push_back('{1'b1, rd(32'h200), c0 + 3});
        sbq.push_back('{1'b0, rd(32'h24), c0 + 7});
        for (int k = 1; k <= 12; k++) begin
            step();
            if (mem_ready) mem_req = 1'b0;
            if (if_ready)  if_req  = 1'b0;
            if (k == 5) begin
                n_checks++;
                if (ram_ce !== 1'b1 || ram_addr !== 32'h24 || ram_sel !== 4'hF) begin
                    n_fail++;
                    $display("FAIL sim_if_access: got ce=%0b addr=%h sel=%h, required ce=1 addr=24 sel=f", ram_ce, ram_addr, ram_sel);
                end
            end
        end
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sim_drain: got %0d pending, required 0", sbq.size());
        end
    endtask

    task automatic test_store();
        int c0 = cyc;
        // Prime mem_rdata_o with 0x1234 via a load.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h80; mem_sel = 4'hF;
        sbq.push_back('{1'b1, 32'h1234, c0 + 3});
        for (int k = 1; k <= 4; k++) begin
            step();
            if (mem_ready) mem_req = 1'b0;
        end
        c0 = cyc;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; mem_sel = 4'b1111;
        sbq.push_back('{1'b1, 32'h1234, c0 + 3});
        for (int k = 1; k <= 2; k++) begin
            step();
            n_checks++;
            if ({ram_ce, ram_we, ram_addr, ram_wdata, ram_sel} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF}) begin
                n_fail++;
                $display("FAIL store_access_c%0d: got ce=%0b we=%0b addr=%h wdata=%h sel=%h, required 1 1 100 deadbeef f",
                         k, ram_ce, ram_we, ram_addr, ram_wdata, ram_sel);
            end
        end
        step();
        n_checks++;
        if (mem_ready !== 1'b1 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL store_resp: got ready=%0b we=%0b, required ready=1 we=0", mem_ready, ram_we);
        end
        mem_req = 1'b0; mem_we = 1'b0;
        step();
        n_checks++;
        if (mem_rdata !== 32'h1234) begin
            n_fail++;
            $display("FAIL store_rdata_hold: got %h, required 00001234", mem_rdata);
        end
    endtask

    task automatic test_streak();
        int c0 = cyc;
        if_req = 1'b1; if_addr = 32'h40;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_sel = 4'hF;
        for (int g = 0; g < 6; g++)
            sbq.push_back('{(g != 4), (g == 4) ? rd(32'h40) : rd(32'h300), c0 + 3 + 4 * g});
        for (int k = 1; k <= 40 && sbq.size() != 0; k++) begin
            step();
            if (cyc == c0 + 23) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL streak_drain: got %0d pending, required 0", sbq.size());
        end
        step();
    endtask

    task automatic test_reset_mid();
        int c0 = cyc;
        if_req = 1'b1; if_addr = 32'h44;
        step();                      // cycle 1: ACCESS
        rst = 1'b0;
        step();                      // cycle 2: back in reset state
        n_checks++;
        if ({if_data, mem_rdata, ram_addr, ram_sel, ram_ce, ram_we, if_ready, mem_ready, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got ce=%0b addr=%h ready=%0b busy=%0b ifd=%h memd=%h, required all 0",
                     ram_ce, ram_addr, if_ready, busy, if_data, mem_rdata);
        end
        rst = 1'b1;                  // cycle 2 is the first IDLE cycle
        sbq.push_back('{1'b0, rd(32'h44), c0 + 5});
        for (int k = 1; k <= 8 && sbq.size() != 0; k++) begin
            step();
            if (if_ready) if_req = 1'b0;
        end
        if_req = 1'b0;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: got %0d pending, required 0", sbq.size());
        end
        step();
    endtask

    task automatic test_lat1_back_to_back();
        int c0 = cyc;
        int seen = 0;
        if_req1 = 1'b1; if_addr1 = 32'h0;
        sbq1.push_back('{1'b0, rd(32'h0), c0 + 2});
        sbq1.push_back('{1'b0, rd(32'h4), c0 + 5});
        for (int k = 1; k <= 10 && seen < 2; k++) begin
            step();
            if (k == 1) begin
                n_checks++;
                if (ram_ce1 !== 1'b1 || ram_addr1 !== 32'h0) begin
                    n_fail++;
                    $display("FAIL lat1_access: got ce=%0b addr=%h, required ce=1 addr=0", ram_ce1, ram_addr1);
                end
            end
            if (if_ready1) begin
                seen++;
                if (seen == 1) if_addr1 = 32'h4;
                else           if_req1  = 1'b0;
            end
        end
        if_req1 = 1'b0;
        step();
        n_checks++;
        if (sbq1.size() != 0) begin
            n_fail++;
            $display("FAIL lat1_drain: got %0d pending, required 0", sbq1.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0;
        if_req1 = 0; if_addr1 = 0; mem_req1 = 0; mem_we1 = 0; mem_addr1 = 0; mem_wdata1 = 0; mem_sel1 = 0;
        test_reset();
        test_if_read();
        test_simultaneous();
        test_store();
        test_streak();
        test_reset_mid();
        test_lat1_back_to_back();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
